// File: rtl/i2s_stereo_rx.sv
// i2s_stereo_rx: framed stereo serial-audio receiver (I2S or left-justified).
// Captures a DATA_W-bit left/right pair and publishes it with a one-clk valid
// strobe; slots ending with fewer than DATA_W bits pulse short_err.
// Optional macro I2S_RX_SYNC_EN: bck/ws/sdin pass through two-flop
// synchronizers (+2 clk latency) when the codec clocks are asynchronous to clk.
//
// state     | meaning
// WAIT_EDGE | idle; waits for a ws boundary into a left slot
// RX_LEFT   | capturing the left slot
// RX_RIGHT  | capturing the right slot; its end publishes the pair
module i2s_stereo_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              enable,
  input  logic              lj_mode,
  input  logic              bck,
  input  logic              ws,
  input  logic              sdin,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid,
  output logic              short_err
);

  typedef enum logic [1:0] {WAIT_EDGE, RX_LEFT, RX_RIGHT} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W:0]    DATA_W_C = (CNT_W+1)'(DATA_W);
  localparam logic [DATA_W-1:0] MSB_ONE  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic              bck_s, ws_s, sdin_s;
  logic              bck_reg, ws_prev, lj_q;
  logic [DATA_W-1:0] shreg, left_hold;
  logic [CNT_W-1:0]  bitcnt;
  logic              rise, bnd, lj_eff, own_bit, short_end;
  logic [DATA_W-1:0] word_now, start_word;
  logic [CNT_W-1:0]  cnt_now, start_cnt;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] bck_sync, ws_sync, sdin_sync;

  // Two-flop synchronizers for the codec pins.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      bck_sync  <= '0;
      ws_sync   <= '0;
      sdin_sync <= '0;
    end else begin
      bck_sync  <= {bck_sync[0], bck};
      ws_sync   <= {ws_sync[0], ws};
      sdin_sync <= {sdin_sync[0], sdin};
    end
  end

  assign bck_s  = bck_sync[1];
  assign ws_s   = ws_sync[1];
  assign sdin_s = sdin_sync[1];
`else
  assign bck_s  = bck;
  assign ws_s   = ws;
  assign sdin_s = sdin;
`endif

  assign rise = !bck_reg && bck_s;
  assign bnd  = rise && (ws_s != ws_prev);

  // Word/count after this rise, and the seed values for a new slot.
  always_comb begin
    lj_eff   = (state == WAIT_EDGE) ? lj_mode : lj_q;
    // In LJ mode the boundary rise already belongs to the next slot.
    own_bit  = rise && !(lj_eff && bnd);
    word_now = shreg;
    cnt_now  = bitcnt;
    if (own_bit) begin
      // The mask shifts out to zero past DATA_W, discarding surplus bits.
      if (sdin_s) word_now = shreg | (MSB_ONE >> bitcnt);
      if (bitcnt != CNT_MAX) cnt_now = bitcnt + CNT_W'(1);
    end
    short_end  = ({1'b0, cnt_now} < DATA_W_C);
    start_word = (lj_eff && sdin_s) ? MSB_ONE : '0;
    start_cnt  = lj_eff ? CNT_W'(1) : '0;
  end

  // Frame FSM: edge tracking, slot capture and pair publication.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= WAIT_EDGE;
      bck_reg    <= 1'b0;
      ws_prev    <= 1'b0;
      lj_q       <= 1'b0;
      shreg      <= '0;
      bitcnt     <= '0;
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      bck_reg   <= bck_s;
      valid     <= 1'b0;
      short_err <= 1'b0;
      if (rise) ws_prev <= ws_s;
      if (!enable) begin
        state  <= WAIT_EDGE;
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        case (state)
          WAIT_EDGE: begin
            lj_q <= lj_mode;
            if (bnd && !ws_s) begin
              state  <= RX_LEFT;
              shreg  <= start_word;
              bitcnt <= start_cnt;
            end
          end
          RX_LEFT: begin
            if (bnd) begin
              left_hold <= word_now;
              short_err <= short_end;
              state     <= RX_RIGHT;
              shreg     <= start_word;
              bitcnt    <= start_cnt;
            end else if (rise) begin
              shreg  <= word_now;
              bitcnt <= cnt_now;
            end
          end
          RX_RIGHT: begin
            if (bnd) begin
              left_data  <= left_hold;
              right_data <= word_now;
              valid      <= 1'b1;
              short_err  <= short_end;
              state      <= RX_LEFT;
              shreg      <= start_word;
              bitcnt     <= start_cnt;
            end else if (rise) begin
              shreg  <= word_now;
              bitcnt <= cnt_now;
            end
          end
          default: state <= WAIT_EDGE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Bench for i2s_stereo_rx: two instances (DATA_W 16 and 24) share the pins.
// Streams are built from slot lists; expected events come from a table of
// constants or from a slot-level reference model.
module tb_i2s_stereo_rx;
  logic clk = 1'b0, nRst = 1'b0, enable = 1'b0, lj_mode = 1'b0;
  logic bck = 1'b0, ws = 1'b0, sdin = 1'b0;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic v16, s16, v24, s24;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;

`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_stereo_rx #(.DATA_W(16), .CNT_W(6)) u_dut16 (
    .clk(clk), .nRst(nRst), .enable(enable), .lj_mode(lj_mode), .bck(bck),
    .ws(ws), .sdin(sdin), .left_data(l16), .right_data(r16), .valid(v16),
    .short_err(s16));

  i2s_stereo_rx #(.DATA_W(24), .CNT_W(6)) u_dut24 (
    .clk(clk), .nRst(nRst), .enable(enable), .lj_mode(lj_mode), .bck(bck),
    .ws(ws), .sdin(sdin), .left_data(l24), .right_data(r24), .valid(v24),
    .short_err(s24));

  typedef struct { bit v; bit s; logic [23:0] l; logic [23:0] r; int c; } ev_t;
  typedef struct { int n; logic [127:0] d; bit w; } slot_t;
  typedef struct {
    bit lj; int nl; int nr; logic [127:0] ld; logic [127:0] rd;
    logic [23:0] l16; logic [23:0] r16; bit ls16; bit rs16;
    logic [23:0] l24; logic [23:0] r24; bit ls24; bit rs24;
  } row_t;

  ev_t   obs16[$], obs24[$], ex16[$], ex24[$];
  slot_t slots[$];
  bit    st_ws[$], st_sd[$];
  int    st_cyc[$], sl_start[$];
  logic [23:0] last_l16 = '0, last_r16 = '0, last_l24 = '0, last_r24 = '0;

  // Observed output events (valid or short_err), stamped with the clk count.
  always @(negedge clk) begin
    if (v16 || s16) obs16.push_back('{v16, s16, {8'h00, l16}, {8'h00, r16}, cyc});
    if (v24 || s24) obs24.push_back('{v24, s24, l24, r24, cyc});
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // First min(n,w) slot bits, MSB first, left-aligned in a w-bit word.
  function automatic logic [23:0] cap(logic [127:0] d, int n, int w);
    logic [127:0] t;
    if (n >= w) t = d >> (n - w);
    else        t = d << (w - n);
    t = t & ((128'd1 << w) - 128'd1);
    return t[23:0];
  endfunction

  function automatic int end_idx(int s, bit lj);
    return lj ? sl_start[s+1] : sl_start[s+1] - 1;
  endfunction

  task automatic add_slot(input bit w, input int n, input logic [127:0] d);
    slots.push_back('{n, d, w});
  endtask

  // Flatten slots to per-bck (ws, sd); I2S moves ws one bck ahead of the MSB.
  task automatic build_stream(input bit lj);
    bit fw[$];
    bit fs[$];
    st_ws.delete(); st_sd.delete(); sl_start.delete();
    foreach (slots[s]) begin
      sl_start.push_back(fw.size());
      for (int j = 0; j < slots[s].n; j++) begin
        fw.push_back(slots[s].w);
        fs.push_back(slots[s].d[slots[s].n - 1 - j]);
      end
    end
    for (int i = 0; i < fw.size(); i++) begin
      st_ws.push_back((lj || i + 1 >= fw.size()) ? fw[i] : fw[i+1]);
      st_sd.push_back(fs[i]);
    end
  endtask

  // Reference model: slots are lead R, (L,R) pairs, tail L.
  task automatic model_expect(input bit lj);
    int p;
    p = (slots.size() - 2) / 2;
    for (int k = 0; k < p; k++) begin
      for (int wi = 0; wi < 2; wi++) begin
        int w;
        ev_t el, er;
        slot_t sl, sr;
        w  = wi ? 24 : 16;
        sl = slots[1 + 2*k];
        sr = slots[2 + 2*k];
        el = '{1'b0, 1'b1, 24'h0, 24'h0, end_idx(1 + 2*k, lj)};
        er = '{1'b1, sr.n < w, cap(sl.d, sl.n, w), cap(sr.d, sr.n, w), end_idx(2 + 2*k, lj)};
        if (wi == 0) begin
          if (sl.n < w) ex16.push_back(el);
          ex16.push_back(er);
        end else begin
          if (sl.n < w) ex24.push_back(el);
          ex24.push_back(er);
        end
      end
    end
  endtask

  task automatic drive_bit(input bit w, input bit d, output int c);
    @(negedge clk); bck = 1'b0; ws = w; sdin = d;
    @(negedge clk);
    @(negedge clk); bck = 1'b1; c = cyc;
    @(negedge clk);
  endtask

  task automatic cmp_q(input int w);
    ev_t e[$];
    ev_t o[$];
    int lat;
    if (w == 16) begin e = ex16; o = obs16; end
    else begin e = ex24; o = obs24; end
    n_cmp++;
    if (o.size() != e.size()) begin
      n_bad++;
      $display("FAIL w%0d event_count: got %0d want %0d", w, o.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      n_cmp++;
      lat = o[i].c - st_cyc[e[i].c];
      if (o[i].v !== e[i].v || o[i].s !== e[i].s || lat != LAT ||
          (e[i].v && (o[i].l !== e[i].l || o[i].r !== e[i].r))) begin
        n_bad++;
        $display("FAIL w%0d event%0d: got v=%0d s=%0d l=%h r=%h lat=%0d want v=%0d s=%0d l=%h r=%h lat=%0d",
                 w, i, o[i].v, o[i].s, o[i].l, o[i].r, lat, e[i].v, e[i].s, e[i].l, e[i].r, LAT);
      end
    end
    foreach (e[i]) begin
      if (e[i].v) begin
        if (w == 16) begin last_l16 = e[i].l; last_r16 = e[i].r; end
        else begin last_l24 = e[i].l; last_r24 = e[i].r; end
      end
    end
  endtask

  task automatic check_hold();
    n_cmp++;
    if ({8'h00, l16} !== last_l16 || {8'h00, r16} !== last_r16 || l24 !== last_l24 || r24 !== last_r24) begin
      n_bad++;
      $display("FAIL hold: got %h/%h %h/%h want %h/%h %h/%h",
               l16, r16, l24, r24, last_l16, last_r16, last_l24, last_r24);
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({l16, r16, v16, s16, l24, r24, v24, s24} !== '0) begin
      n_bad++;
      $display("FAIL %s: got l16=%h r16=%h v=%0d s=%0d l24=%h r24=%h v=%0d s=%0d want all 0",
               tag, l16, r16, v16, s16, l24, r24, v24, s24);
    end
  endtask

  task automatic run_phase(input bit lj, input int abort_at, input int resume_at);
    int c;
    lj_mode = lj;
    enable  = 1'b1;
    st_cyc.delete();
    for (int i = 0; i < st_ws.size(); i++) begin
      if (i == abort_at) enable = 1'b0;
      if (i == resume_at) begin enable = 1'b1; check_hold(); end
      drive_bit(st_ws[i], st_sd[i], c);
      st_cyc.push_back(c);
    end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    cmp_q(16);
    cmp_q(24);
    obs16.delete(); obs24.delete(); ex16.delete(); ex24.delete();
  endtask

  function automatic int rlen();
    return ($urandom_range(7, 0) == 0) ? 70 : int'($urandom_range(40, 8));
  endfunction

  row_t rows[5];

  initial begin
    bit lj;
    int c;
    rows[0] = '{1'b0, 32, 32, 128'hA5C3_0000, 128'h1234_0000,
                24'hA5C3, 24'h1234, 1'b0, 1'b0, 24'hA5C300, 24'h123400, 1'b0, 1'b0};
    rows[1] = '{1'b1, 24, 24, 128'h800001, 128'h7FFFFE,
                24'h8000, 24'h7FFF, 1'b0, 1'b0, 24'h800001, 24'h7FFFFE, 1'b0, 1'b0};
    rows[2] = '{1'b0, 32, 12, 128'h5A5A_FFFF, 128'hABC,
                24'h5A5A, 24'hABC0, 1'b0, 1'b1, 24'h5A5AFF, 24'hABC000, 1'b0, 1'b1};
    rows[3] = '{1'b1, 10, 20, 128'h2AB, 128'hF0F0F,
                24'hAAC0, 24'hF0F0, 1'b1, 1'b0, 24'hAAC000, 24'hF0F0F0, 1'b1, 1'b1};
    rows[4] = '{1'b0, 70, 16, (128'hC3A5 << 54) | ((128'd1 << 54) - 128'd1), 128'h0F0F,
                24'hC3A5, 24'h0F0F, 1'b0, 1'b0, 24'hC3A5FF, 24'h0F0F00, 1'b0, 1'b1};

    #1;
    check_zero("reset_state");
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed rows: two identical frames each, expectations from the table.
    for (int r = 0; r < 5; r++) begin
      slots.delete();
      add_slot(1'b1, 32, 128'h0);
      for (int k = 0; k < 2; k++) begin
        add_slot(1'b0, rows[r].nl, rows[r].ld);
        add_slot(1'b1, rows[r].nr, rows[r].rd);
      end
      add_slot(1'b0, 4, 128'h0);
      build_stream(rows[r].lj);
      for (int k = 0; k < 2; k++) begin
        if (rows[r].ls16) ex16.push_back('{1'b0, 1'b1, 24'h0, 24'h0, end_idx(1 + 2*k, rows[r].lj)});
        ex16.push_back('{1'b1, rows[r].rs16, rows[r].l16, rows[r].r16, end_idx(2 + 2*k, rows[r].lj)});
        if (rows[r].ls24) ex24.push_back('{1'b0, 1'b1, 24'h0, 24'h0, end_idx(1 + 2*k, rows[r].lj)});
        ex24.push_back('{1'b1, rows[r].rs24, rows[r].l24, rows[r].r24, end_idx(2 + 2*k, rows[r].lj)});
      end
      run_phase(rows[r].lj, -1, -1);
    end

    // Enable dropped mid right slot: first pair discarded, second received.
    slots.delete();
    add_slot(1'b1, 32, rnd128());
    for (int k = 0; k < 2; k++) begin
      add_slot(1'b0, 32, rnd128());
      add_slot(1'b1, 32, rnd128());
    end
    add_slot(1'b0, 8, rnd128());
    build_stream(1'b0);
    model_expect(1'b0);
    void'(ex16.pop_front());
    void'(ex24.pop_front());
    run_phase(1'b0, sl_start[2] + 8, sl_start[2] + 20);

    // Async reset in the middle of a left slot.
    slots.delete();
    add_slot(1'b1, 32, rnd128());
    add_slot(1'b0, 32, rnd128());
    add_slot(1'b1, 32, rnd128());
    add_slot(1'b0, 8, rnd128());
    build_stream(1'b0);
    lj_mode = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < sl_start[1] + 10; i++) drive_bit(st_ws[i], st_sd[i], c);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    nRst   = 1'b1;
    repeat (2) @(negedge clk);
    obs16.delete(); obs24.delete();
    last_l16 = '0; last_r16 = '0; last_l24 = '0; last_r24 = '0;

    // Randomized phases against the slot-level model.
    for (int p = 0; p < 10; p++) begin
      int np;
      slots.delete();
      lj = 1'($urandom_range(1, 0));
      np = $urandom_range(3, 1);
      add_slot(1'b1, $urandom_range(40, 2), rnd128());
      for (int k = 0; k < np; k++) begin
        add_slot(1'b0, rlen(), rnd128());
        add_slot(1'b1, rlen(), rnd128());
      end
      add_slot(1'b0, $urandom_range(8, 2), rnd128());
      build_stream(lj);
      model_expect(lj);
      run_phase(lj, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2s_stereo_rx.md
# i2s_stereo_rx

Parametrised stereo serial-audio receiver for the audio mixer datapath. It replaces the single-lane, free-running 16-bit shifter with a framed receiver that:
- decodes the codec word-select line and supports I2S or left-justified framing;
- captures a configurable-width left/right sample pair;
- presents the pair with a one-cycle valid strobe and flags short slots.

It sits between the UDA1341TS serial pins and the mixer input stage, entirely in the `clk` domain.

## Interface
- DATA_W, 16: sample width captured per channel; legal 8..24.
- CNT_W, 6: width of the per-slot bit counter; slots up to 2^CNT_W-1 bck periods.
- clk  in  1  system clock; frequency ≥ 4× bck.
- nRst  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = receive; 0 = abort frame, return to WAIT_EDGE.
- lj_mode  in  1  0 = I2S (MSB one bck after ws change), 1 = left-justified (MSB on first bck after ws change). Sampled only in WAIT_EDGE.
- bck  in  1  codec bit clock.
- ws  in  1  word select; 0 = left slot, 1 = right slot.
- sdin  in  1  serial data, MSB first.
- left_data  out  DATA_W  last complete left sample.
- right_data  out  DATA_W  last complete right sample.
- valid  out  1  one-clk pulse: left_data/right_data updated as a pair.
- short_err  out  1  one-clk pulse: a slot ended with fewer than DATA_W bits.

## Operation
- Edge detect: `bck_reg` registers bck each clk. A rising edge (rise) is `bck_reg==0 && bck==1`. All sampling of ws/sdin happens on rise cycles only.
- `ws_prev` is updated on each rise. A slot boundary (bnd) is a rise where ws ≠ ws_prev.
- Slot start:
  - LJ mode: the bnd rise itself is bit 0 (MSB).
  - I2S mode: the bnd rise carries the previous slot's final bit and is counted in the old slot. The next rise is bit 0.
- States:
  - WAIT_EDGE: entered on reset or enable=0. Ignores data. On a bnd with new ws=0, goes to RX_LEFT, aligned per mode; a right slot is never captured first.
  - RX_LEFT: shifts sdin into `shreg` MSB-first while bitcnt < DATA_W; bits beyond DATA_W are discarded. On the ending bnd, the word is latched into `left_hold` and the state goes to RX_RIGHT.
  - RX_RIGHT: same capture. On the ending bnd, `left_data`←`left_hold`, `right_data`←word, valid=1, and the state goes to RX_LEFT.
- Early completion: when bitcnt reaches DATA_W, the word is complete. The transfer still occurs at the slot end, not earlier.
- Short slot: if a slot ends with bitcnt < DATA_W, the word is left-aligned with zeros in the missing LSBs, short_err pulses, and the transfer still proceeds.
- bitcnt saturates at 2^CNT_W-1; there is no wrap.
- enable falling mid-frame: the partial pair is discarded, the state goes to WAIT_EDGE, and outputs hold their last values. No valid or short_err pulse is issued.
- Async nRst mid-frame: all state is cleared immediately.

## Timing
- Reset values: left_data=0, right_data=0, valid=0, short_err=0, state=WAIT_EDGE, shreg=0, bitcnt=0, ws_prev=0, bck_reg=0.
- valid and short_err are registered and go high in the clk cycle after the rise cycle that ends the right slot. They are high for exactly one clk.
- short_err for a short left slot fires one clk after that slot's ending rise, independent of valid.
- Latency, default build: last-bit rise cycle to valid = 1 clk. With I2S_RX_SYNC_EN: +2 clk.
- Input constraints: bck high and low each ≥ 2 clk. ws and sdin stable across the rise.
- Simultaneous enable=0 and ending bnd: enable wins, and no valid is issued.

## Configuration
- I2S_RX_SYNC_EN defined: bck, ws and sdin each pass through a two-flop synchronizer (reset 0) before edge detection and sampling. This adds 2 clk latency and is used when the codec clocks are asynchronous to clk.
- Undefined: inputs are used directly, the codec clock is assumed derived from clk, and latency is as stated above.

## Test plan
- I2S, DATA_W=16, 32-bck slots, left=16'hA5C3, right=16'h1234 -> one valid pulse per frame; left_data=16'hA5C3, right_data=16'h1234; short_err never asserts.
- LJ mode, DATA_W=24, 24-bck slots, left=24'h800001, right=24'h7FFFFE -> valid each frame with exact values; MSB is taken from the bnd rise.
- I2S, DATA_W=16, 12-bck right slot carrying 12'hABC -> right_data=16'hABC0; short_err pulses once, coincident with valid.
- Enable low during a right slot, then high -> no valid for that frame; outputs hold previous values; next complete frame after a left boundary is received correctly.
- nRst asserted mid left slot -> all outputs 0 asynchronously; the first frame after release starting with a right slot is ignored; the following L/R pair is valid.
- Build with I2S_RX_SYNC_EN, same stimulus as scenario 1 -> identical data, with valid 2 clk later than in the default build.
